// File: rtl/zoom_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zoom_pkg
// Purpose  : Shared definitions for the zoom job controller, the zoom
//            datapath and the command front end: controller state encoding,
//            algorithm codes and zoom-level limits.
// Revision : 1.0 - initial release
// ============================================================================
package zoom_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_SWAP  = 2'd3
    } zoom_state_t;

    // Algorithm codes driven to the datapath algorithm_select
    localparam logic [1:0] ALG_NN  = 2'd0;
    localparam logic [1:0] ALG_PR  = 2'd1;
    localparam logic [1:0] ALG_DEC = 2'd2;
    localparam logic [1:0] ALG_BA  = 2'd3;

    // Zoom levels 0..ZOOM_MAX are legal; ZOOM_DEFAULT is 1x
    localparam logic [2:0] ZOOM_MAX     = 3'd4;
    localparam logic [2:0] ZOOM_DEFAULT = 3'd2;

    function automatic logic zoom_is_valid(input logic [2:0] zoom);
        return (zoom <= ZOOM_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/zoom_job_timer.sv
`default_nettype none
// ============================================================================
// Module   : zoom_job_timer
// Purpose  : Saturating cycle counter with synchronous clear, count enable
//            and a terminal-count flag. Used for both the settle delay and
//            the RUN watchdog.
// Ports    : clk, rst_n        clock, async active-low reset
//            clr               synchronous clear (wins over en)
//            en                count enable
//            term              terminal count to compare against
//            count             current count
//            count_inc         count + 1, saturated at all-ones
//            at_term           current cycle is the term-th counted cycle
// Revision : 1.0 - initial release
// ============================================================================
module zoom_job_timer #(
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_inc,
    output logic             at_term
);

    // count holds the number of cycles already completed, so count_inc is
    // the ordinal of the cycle in progress.
    assign count_inc = (count == '1) ? count : count + 1'b1;
    assign at_term   = (count_inc >= term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/zoom_job_controller.sv
`default_nettype none
// ============================================================================
// Module   : zoom_job_controller
// Purpose  : Runs one zoom job at a time: accepts and validates a command,
//            holds algorithm/zoom stable, sequences datapath enable through
//            CLEAR and RUN, supervises RUN with a watchdog and finishes with
//            a double-buffer swap handshake.
// Ports    : cmd_valid/cmd_ready/cmd_alg/cmd_zoom  command handshake
//            abort                                 cancel active job (level)
//            dp_enable/dp_alg/dp_zoom/dp_done      datapath control
//            swap_req/swap_ack/front_bank          display bank swap
//            busy/job_done/err_invalid/err_timeout status
//            last_cycles                           RUN length of last job
// Revision : 1.0 - initial release
// ============================================================================
module zoom_job_controller
    import zoom_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 400000,
    parameter int SETTLE_CYCLES  = 2,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_alg,
    input  logic [2:0]       cmd_zoom,
    input  logic             abort,
    output logic             dp_enable,
    output logic [1:0]       dp_alg,
    output logic [2:0]       dp_zoom,
    input  logic             dp_done,
    output logic             swap_req,
    input  logic             swap_ack,
    output logic             front_bank,
    output logic             busy,
    output logic             job_done,
    output logic             err_invalid,
    output logic             err_timeout,
    output logic [CNT_W-1:0] last_cycles
);

    localparam logic [CNT_W-1:0] C_SETTLE  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    zoom_state_t      r_state;
    logic             w_timer_clr;
    logic             w_timer_en;
    logic [CNT_W-1:0] w_timer_term;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_at_term;
    logic             w_done_ok;

    assign cmd_ready = (r_state == ST_IDLE);

    // The timer is held clear in IDLE and cleared again on the CLEAR->RUN
    // transition, so during RUN it counts completed RUN cycles.
    always_comb begin
        w_timer_clr  = (r_state == ST_IDLE) || ((r_state == ST_CLEAR) && w_at_term);
        w_timer_en   = (r_state == ST_CLEAR) || (r_state == ST_RUN);
        w_timer_term = (r_state == ST_CLEAR) ? C_SETTLE : C_TIMEOUT;
    end

    zoom_job_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_timer_clr),
        .en        (w_timer_en),
        .term      (w_timer_term),
        .count     (w_count),
        .count_inc (w_count_inc),
        .at_term   (w_at_term)
    );

    // A done left over from the previous job can still be high in the first
    // RUN cycle (count == 0), so it is only honoured from the second cycle.
    assign w_done_ok = dp_done && (w_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            dp_enable   <= 1'b0;
            dp_alg      <= ALG_NN;
            dp_zoom     <= ZOOM_DEFAULT;
            swap_req    <= 1'b0;
            front_bank  <= 1'b0;
            busy        <= 1'b0;
            job_done    <= 1'b0;
            err_invalid <= 1'b0;
            err_timeout <= 1'b0;
            last_cycles <= '0;
        end else begin
            job_done    <= 1'b0;
            err_invalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (zoom_is_valid(cmd_zoom)) begin
                            dp_alg      <= cmd_alg;
                            dp_zoom     <= cmd_zoom;
                            err_timeout <= 1'b0;
                            busy        <= 1'b1;
                            r_state     <= ST_CLEAR;
                        end else begin
                            err_invalid <= 1'b1;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_at_term) begin
                        dp_enable <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Priority: done, then abort, then watchdog
                    if (w_done_ok) begin
                        last_cycles <= w_count_inc;
                        dp_enable   <= 1'b0;
                        swap_req    <= 1'b1;
                        r_state     <= ST_SWAP;
                    end else if (abort) begin
                        dp_enable <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_at_term) begin
                        err_timeout <= 1'b1;
                        dp_enable   <= 1'b0;
                        busy        <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_SWAP: begin
                    // Abort is deliberately ignored: a started swap completes
                    if (swap_ack) begin
                        swap_req   <= 1'b0;
                        front_bank <= ~front_bank;
                        job_done   <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zoom_job_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_zoom_job_controller
// Purpose  : Self-checking bench for zoom_job_controller. A main instance
//            (default watchdog) covers command validation, a full job,
//            stale done, abort and reset; a second instance with a short
//            watchdog covers the timeout path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zoom_job_controller;

    localparam int CW  = $clog2(400000 + 1);
    localparam int CW2 = $clog2(50 + 1);

    logic          clk;
    logic          rst_n;

    // Main instance
    logic          cmd_valid, abort, dp_done, swap_ack;
    logic [1:0]    cmd_alg;
    logic [2:0]    cmd_zoom;
    logic          cmd_ready, dp_enable, swap_req, front_bank, busy;
    logic          job_done, err_invalid, err_timeout;
    logic [1:0]    dp_alg;
    logic [2:0]    dp_zoom;
    logic [CW-1:0] last_cycles;

    // Short-watchdog instance
    logic           t_cmd_valid, t_abort, t_dp_done, t_swap_ack;
    logic [1:0]     t_cmd_alg;
    logic [2:0]     t_cmd_zoom;
    logic           t_cmd_ready, t_dp_enable, t_swap_req, t_front_bank, t_busy;
    logic           t_job_done, t_err_invalid, t_err_timeout;
    logic [1:0]     t_dp_alg;
    logic [2:0]     t_dp_zoom;
    logic [CW2-1:0] t_last_cycles;

    int n_checks = 0;
    int n_errors = 0;

    zoom_job_controller u_dut (
        .clk (clk), .rst_n (rst_n),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_alg (cmd_alg), .cmd_zoom (cmd_zoom), .abort (abort),
        .dp_enable (dp_enable), .dp_alg (dp_alg), .dp_zoom (dp_zoom),
        .dp_done (dp_done), .swap_req (swap_req), .swap_ack (swap_ack),
        .front_bank (front_bank), .busy (busy), .job_done (job_done),
        .err_invalid (err_invalid), .err_timeout (err_timeout),
        .last_cycles (last_cycles)
    );

    zoom_job_controller #(
        .TIMEOUT_CYCLES (50)
    ) u_dut_to (
        .clk (clk), .rst_n (rst_n),
        .cmd_valid (t_cmd_valid), .cmd_ready (t_cmd_ready),
        .cmd_alg (t_cmd_alg), .cmd_zoom (t_cmd_zoom), .abort (t_abort),
        .dp_enable (t_dp_enable), .dp_alg (t_dp_alg), .dp_zoom (t_dp_zoom),
        .dp_done (t_dp_done), .swap_req (t_swap_req), .swap_ack (t_swap_ack),
        .front_bank (t_front_bank), .busy (t_busy), .job_done (t_job_done),
        .err_invalid (t_err_invalid), .err_timeout (t_err_timeout),
        .last_cycles (t_last_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] alg;
        logic [2:0] zoom;
        logic       acc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"},   cmd_ready,   1);
        check({tag, "_dp_enable"},   dp_enable,   0);
        check({tag, "_dp_alg"},      dp_alg,      0);
        check({tag, "_dp_zoom"},     dp_zoom,     2);
        check({tag, "_swap_req"},    swap_req,    0);
        check({tag, "_front_bank"},  front_bank,  0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_job_done"},    job_done,    0);
        check({tag, "_err_invalid"}, err_invalid, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
        check({tag, "_last_cycles"}, last_cycles, 0);
    endtask

    // Present a command for one edge on the main instance
    task automatic accept(input logic [1:0] alg, input logic [2:0] zoom);
        cmd_valid = 1'b1;
        cmd_alg   = alg;
        cmd_zoom  = zoom;
        check("accept_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait for dp_enable to rise; returns the number of edges waited
    task automatic wait_en(output int n);
        n = 0;
        while (!dp_enable && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        vec_t tbl[6];
        logic [1:0] m_alg;
        logic [2:0] m_zoom;
        int n, hi, bad;

        tbl[0] = '{alg: 2'd3, zoom: 3'd4, acc: 1'b1};
        tbl[1] = '{alg: 2'd0, zoom: 3'd6, acc: 1'b0};
        tbl[2] = '{alg: 2'd1, zoom: 3'd0, acc: 1'b1};
        tbl[3] = '{alg: 2'd2, zoom: 3'd5, acc: 1'b0};
        tbl[4] = '{alg: 2'd0, zoom: 3'd7, acc: 1'b0};
        tbl[5] = '{alg: 2'd2, zoom: 3'd3, acc: 1'b1};
        m_alg  = 2'd0;
        m_zoom = 3'd2;

        cmd_valid = 0; cmd_alg = 0; cmd_zoom = 0; abort = 0; dp_done = 0; swap_ack = 0;
        t_cmd_valid = 0; t_cmd_alg = 0; t_cmd_zoom = 0; t_abort = 0; t_dp_done = 0; t_swap_ack = 0;

        // ---------------- reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        check("por_t_cmd_ready", t_cmd_ready, 1);
        check("por_t_err_timeout", t_err_timeout, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- command validation table (accepted jobs aborted in CLEAR)
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_alg   = tbl[i].alg;
            cmd_zoom  = tbl[i].zoom;
            check($sformatf("vec%0d_cmd_ready", i), cmd_ready, 1);
            tick();
            cmd_valid = 1'b0;
            if (tbl[i].acc) begin
                m_alg  = tbl[i].alg;
                m_zoom = tbl[i].zoom;
            end
            check($sformatf("vec%0d_err_invalid", i), err_invalid, !tbl[i].acc);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].acc);
            check($sformatf("vec%0d_dp_alg", i), dp_alg, m_alg);
            check($sformatf("vec%0d_dp_zoom", i), dp_zoom, m_zoom);
            if (tbl[i].acc) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check($sformatf("vec%0d_abort_busy", i), busy, 0);
                check($sformatf("vec%0d_abort_ready", i), cmd_ready, 1);
                check($sformatf("vec%0d_abort_swap", i), swap_req, 0);
            end else begin
                tick();
                check($sformatf("vec%0d_inv_pulse", i), err_invalid, 0);
                check($sformatf("vec%0d_inv_busy", i), busy, 0);
            end
            check($sformatf("vec%0d_dp_enable", i), dp_enable, 0);
        end

        // ---------------- full job: alg 3 zoom 4, done at RUN cycle 100
        accept(2'd3, 3'd4);
        check("job_dp_alg", dp_alg, 3);
        check("job_dp_zoom", dp_zoom, 4);
        wait_en(n);
        check("job_settle_edges", n, 2);
        hi = 1;
        for (int k = 0; k < 99; k++) begin
            tick();
            if (dp_enable) hi++;
        end
        dp_done = 1'b1;
        tick();
        dp_done = 1'b0;
        check("job_enable_cycles", hi, 100);
        check("job_dp_enable_low", dp_enable, 0);
        check("job_swap_req", swap_req, 1);
        check("job_last_cycles", last_cycles, 100);
        check("job_front_before", front_bank, 0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (!swap_req || job_done || dp_enable || !busy) bad++;
        end
        check("job_swap_hold", bad, 0);
        swap_ack = 1'b1;
        tick();
        swap_ack = 1'b0;
        check("job_front_after", front_bank, 1);
        check("job_done_pulse", job_done, 1);
        check("job_ready_after", cmd_ready, 1);
        check("job_swap_dropped", swap_req, 0);

        // ---------------- back-to-back job with stale done held into RUN cycle 1
        dp_done = 1'b1;
        accept(2'd1, 3'd0);
        check("b2b_job_done_single", job_done, 0);
        check("b2b_busy", busy, 1);
        wait_en(n);
        check("b2b_settle_edges", n, 2);
        tick();
        check("stale_done_ignored", swap_req, 0);
        check("stale_still_running", dp_enable, 1);
        dp_done = 1'b0;
        repeat (3) tick();
        dp_done = 1'b1;
        abort   = 1'b1;
        tick();
        dp_done = 1'b0;
        check("done_beats_abort", swap_req, 1);
        check("done_abort_last_cycles", last_cycles, 5);
        tick();
        check("swap_abort_ignored", swap_req, 1);
        check("swap_abort_busy", busy, 1);
        abort    = 1'b0;
        swap_ack = 1'b1;
        tick();
        swap_ack = 1'b0;
        check("swap_abort_job_done", job_done, 1);
        check("swap_abort_front", front_bank, 0);

        // ---------------- abort at RUN cycle 10
        tick();
        accept(2'd0, 3'd2);
        wait_en(n);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("run_abort_busy", busy, 0);
        check("run_abort_enable", dp_enable, 0);
        check("run_abort_ready", cmd_ready, 1);
        check("run_abort_last_cycles", last_cycles, 5);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (swap_req || job_done) bad++;
            tick();
        end
        check("run_abort_no_swap", bad, 0);

        // ---------------- asynchronous reset at RUN cycle 20
        accept(2'd2, 3'd1);
        wait_en(n);
        repeat (19) tick();
        check("prereset_enable", dp_enable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", cmd_ready, 1);
        check("post_reset_busy", busy, 0);

        // ---------------- watchdog on the short-timeout instance
        t_cmd_valid = 1'b1;
        t_cmd_alg   = 2'd1;
        t_cmd_zoom  = 3'd1;
        tick();
        t_cmd_valid = 1'b0;
        n = 0;
        while (!t_dp_enable && n < 20) begin
            tick();
            n++;
        end
        check("to_settle_edges", n, 2);
        hi  = 0;
        bad = 0;
        n   = 0;
        while (t_dp_enable && n < 200) begin
            hi++;
            tick();
            n++;
            if (t_swap_req) bad++;
        end
        check("to_run_cycles", hi, 50);
        check("to_err_timeout", t_err_timeout, 1);
        check("to_busy", t_busy, 0);
        check("to_ready", t_cmd_ready, 1);
        check("to_front_bank", t_front_bank, 0);
        check("to_no_swap", bad, 0);
        check("to_last_cycles", t_last_cycles, 0);
        repeat (3) tick();
        check("to_sticky", t_err_timeout, 1);
        t_cmd_valid = 1'b1;
        t_cmd_zoom  = 3'd0;
        tick();
        t_cmd_valid = 1'b0;
        check("to_cleared_on_accept", t_err_timeout, 0);
        check("to_accept_busy", t_busy, 1);
        t_abort = 1'b1;
        tick();
        t_abort = 1'b0;
        check("to_abort_busy", t_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
